dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the CPU memory-side blocks.
//   state_t : data-memory controller FSM states (IDLE, WAIT, RESP)
//   err_t   : access error classification (ERR_NONE, ERR_ALIGN, ERR_RANGE)
//   op_t    : latched access direction
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2
  } err_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word-wide storage.
//   clk   : clock, all activity on the rising edge
//   en    : access enable
//   we    : write (1) / read (0) when enabled
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, updated only by an enabled read
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage has no reset on purpose: contents survive rst, and a
  // resettable array would stop mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with a fixed number of wait states.
//   clk             : single clock, rising edge
//   rst             : synchronous active-high reset (memory contents kept)
//   dmem_addr       : CPU byte address
//   dmem_write_data : store data
//   dmem_read_en    : load request
//   dmem_write_en   : store request (wins over a simultaneous load)
//   dmem_read_data  : load data, non-zero only during a good read response
//   dmem_ready      : one-cycle completion pulse
//   dmem_err        : misaligned / out-of-range flag, qualified by dmem_ready
//   busy            : high whenever the FSM is not in IDLE
module dmem_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic                  dmem_read_en,
  input  logic                  dmem_write_en,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  output logic                  dmem_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  // Counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES cycles, leaving on the cycle it reads zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state;
  logic [3:0]            cnt;
  op_t                   op_q;
  err_t                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q;
  logic                  err_flag_q;
  logic                  busy_q;

  logic                  req;
  op_t                   req_op;
  err_t                  in_err;
  logic                  arr_rd;
  logic                  arr_wr;
  logic [IDX_W-1:0]      arr_addr;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign req    = dmem_read_en | dmem_write_en;
  assign req_op = dmem_write_en ? OP_WRITE : OP_READ;

  // Classify the incoming address while still in IDLE so the error is
  // already known when RESP is entered directly (WAIT_STATES = 0).
  // NOTE: every signal assigned in always_comb gets a default first;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    in_err = ERR_NONE;
    if (dmem_addr[1:0] != 2'b00)
      in_err = ERR_ALIGN;
    else if ((dmem_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH))
      in_err = ERR_RANGE;
  end

  // The array read is issued on the edge that enters RESP, so read data
  // reflects memory at RESP entry. With no wait states that edge is the
  // IDLE sampling edge, hence the address comes straight from the bus.
  assign arr_addr = (state == IDLE) ? dmem_addr[IDX_W+1:2] : idx_q;

  assign arr_rd = !rst &&
                  (((state == IDLE) && req && !dmem_write_en && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0) && (op_q == OP_READ)));

  // The write lands on the edge that leaves RESP; a reset in RESP blocks it.
  assign arr_wr = !rst && (state == RESP) && (op_q == OP_WRITE) && (err_q == ERR_NONE);

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (arr_rd | arr_wr),
    .we   (arr_wr),
    .addr (arr_addr),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_q       <= OP_READ;
      err_q      <= ERR_NONE;
      idx_q      <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q    <= 1'b0;
          err_flag_q <= 1'b0;
          busy_q     <= 1'b0;
          if (req) begin
            op_q    <= req_op;
            err_q   <= in_err;
            idx_q   <= dmem_addr[IDX_W+1:2];
            wdata_q <= dmem_write_data;
            busy_q  <= 1'b1;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state      <= RESP;
              ready_q    <= 1'b1;
              err_flag_q <= (in_err != ERR_NONE);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            ready_q    <= 1'b1;
            err_flag_q <= (err_q != ERR_NONE);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          ready_q    <= 1'b0;
          err_flag_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ready_q    <= 1'b0;
          err_flag_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_ready     = ready_q;
  assign dmem_err       = err_flag_q;
  assign busy           = busy_q;
  assign dmem_read_data = (ready_q && !err_flag_q && (op_q == OP_READ)) ? arr_rdata : '0;

endmodule
